lsu_mmio_ctrl: RTL

Parametrised load/store unit between the core datapath and the data memory, with a small memory-mapped I/O window. It accepts one load or store at a time over a valid/ready handshake and sizes, aligns and sign- or zero-extends the data. Misaligned accesses are split into two aligned memory beats, and the unit waits on a memory acknowledge. MMIO output registers and synchronised input pins are served locally without a memory beat.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/bit_synchronizer.sv | 26 ++
 rtl/lsu_mmio_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit and its MMIO window.
// Holds the FSM state encoding, access sizes and the MMIO register stride.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam int MMIO_STRIDE = 4;

    // funct3[1:0]: 00 byte, 01 half, 1x word
    function automatic lsu_size_e decode_size(input logic [1:0] f3_size);
        if (f3_size[1])      return SZ_WORD;
        else if (f3_size[0]) return SZ_HALF;
        else                 return SZ_BYTE;
    endfunction

    function automatic logic [2:0] size_bytes(input lsu_size_e sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-stage flop chain that brings asynchronous pins into the clk_i domain.
// Synchronous active-high reset clears every stage.
module bit_synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) chain_q[s] <= '0;
        end else begin
            chain_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) chain_q[s] <= chain_q[s-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/lsu_mmio_ctrl.sv
// Load/store unit: sizes, lane-aligns and extends data, splits misaligned
// accesses into two memory beats, and serves a small MMIO window locally.
//
// state | meaning
// IDLE  | ready for a request; MMIO accesses complete from here
// BEAT0 | first (lower) aligned memory beat, waiting on mem_ack_i
// BEAT1 | second beat of a split access, word above BEAT0
// RESP  | one-cycle response pulse, no accept
module lsu_mmio_ctrl
    import lsu_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(32'h4000),
    parameter int                N_OUT       = 2,
    parameter int                OUT_W       = 4,
    parameter int                IN_W        = 4,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [2:0]             req_funct3_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [31:0]            rsp_rdata_o,
    output logic                   mem_req_o,
    output logic [3:0]             mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [31:0]            mem_rdata_i,
    input  logic [IN_W-1:0]        sw_i,
    output logic [N_OUT*OUT_W-1:0] out_o
);

    lsu_state_e state_q, state_d;

    logic [IN_W-1:0]        sw_sync;
    logic [N_OUT*OUT_W-1:0] out_q;

    logic [ADDR_W-3:0] word_q;
    logic [1:0]        off_q;
    lsu_size_e         size_q;
    logic              uns_q;
    logic              we_q;
    logic              split_q;
    logic [63:0]       win_q;
    logic [7:0]        mask_q;
    logic [31:0]       lo_q;
    logic [31:0]       rdata_q;

    bit_synchronizer #(
        .WIDTH  (IN_W),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (sw_i),
        .sync_o  (sw_sync)
    );

    // Request decode: MMIO hit, sized store window and split detection
    logic              accept;
    logic [ADDR_W-1:0] mmio_off;
    logic [N_OUT-1:0]  hit_out;
    logic              hit_sw;
    logic              is_mmio;
    logic [31:0]       mmio_rdata;
    lsu_size_e         size_in;
    logic [31:0]       sized_in;
    logic [7:0]        bmask_in;
    logic [63:0]       win_in;
    logic [7:0]        mask_in;
    logic              split_in;

    assign accept   = req_valid_i && (state_q == ST_IDLE);
    assign mmio_off = req_addr_i - MMIO_BASE;
    assign size_in  = decode_size(req_funct3_i[1:0]);

    always_comb begin
        hit_out    = '0;
        mmio_rdata = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit_out[k] = (mmio_off == ADDR_W'(MMIO_STRIDE * k));
            if (hit_out[k]) mmio_rdata[OUT_W-1:0] = out_q[k*OUT_W +: OUT_W];
        end
        hit_sw = (mmio_off == ADDR_W'(MMIO_STRIDE * N_OUT));
        if (hit_sw) mmio_rdata[IN_W-1:0] = sw_sync;
        is_mmio = (|hit_out) || hit_sw;
    end

    always_comb begin
        case (size_in)
            SZ_BYTE: begin sized_in = {24'b0, req_wdata_i[7:0]};  bmask_in = 8'h01; end
            SZ_HALF: begin sized_in = {16'b0, req_wdata_i[15:0]}; bmask_in = 8'h03; end
            default: begin sized_in = req_wdata_i;                bmask_in = 8'h0F; end
        endcase
        win_in   = req_we_i ? ({32'b0, sized_in} << {req_addr_i[1:0], 3'b000}) : 64'b0;
        mask_in  = req_we_i ? (bmask_in << req_addr_i[1:0]) : 8'h00;
        split_in = ({1'b0, req_addr_i[1:0]} + size_bytes(size_in)) > 3'd4;
    end

    // Load extend: BEAT1 supplies the high word, a single beat has none
    logic [63:0] load_win;
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        load_win = (state_q == ST_BEAT1) ? {mem_rdata_i, lo_q} : {32'b0, mem_rdata_i};
        shifted  = 32'(load_win >> {off_q, 3'b000});
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = is_mmio ? ST_RESP : ST_BEAT0;
            end
            ST_BEAT0: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {word_q, 2'b00};
                mem_we_o    = mask_q[3:0];
                mem_wdata_o = win_q[31:0];
                if (mem_ack_i) state_d = split_q ? ST_BEAT1 : ST_RESP;
            end
            ST_BEAT1: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {word_q + 1'b1, 2'b00};
                mem_we_o    = mask_q[7:4];
                mem_wdata_o = win_q[63:32];
                if (mem_ack_i) state_d = ST_RESP;
            end
            default: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = rdata_q;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            word_q  <= '0;
            off_q   <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            split_q <= 1'b0;
            win_q   <= '0;
            mask_q  <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                word_q  <= req_addr_i[ADDR_W-1:2];
                off_q   <= req_addr_i[1:0];
                size_q  <= size_in;
                uns_q   <= req_funct3_i[2];
                we_q    <= req_we_i;
                split_q <= split_in;
                win_q   <= win_in;
                mask_q  <= mask_in;
                lo_q    <= '0;
                rdata_q <= (is_mmio && !req_we_i) ? mmio_rdata : 32'b0;
                for (int k = 0; k < N_OUT; k++) begin
                    if (req_we_i && hit_out[k]) out_q[k*OUT_W +: OUT_W] <= req_wdata_i[OUT_W-1:0];
                end
            end
            if (state_q == ST_BEAT0 && mem_ack_i) begin
                lo_q <= mem_rdata_i;
                if (!split_q) rdata_q <= we_q ? 32'b0 : load_val;
            end
            if (state_q == ST_BEAT1 && mem_ack_i) rdata_q <= we_q ? 32'b0 : load_val;
        end
    end

    assign out_o = out_q;

endmodule
